lsu_mem_access: RTL

Memory-access stage of the pipelined LSU, directly downstream of the M-stage control register that produces the registered `memrq` and `memwq` strobes. It turns a registered load or store request into a single valid/ack transaction on the data-memory bus. It also lane-shifts and byte-masks store data, and aligns and extends load data. While a transaction is outstanding it asserts `stall`, which upstream uses as `pipe_en = ~stall`.

---
 rtl/lsu_mem_access.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: one valid/ack bus transaction per M-stage load/store,
// with store lane placement and load alignment/extension.
module lsu_mem_access #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          memrq_i,
  input  logic          memwq_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [2:0]    funct3_i,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic [3:0]    bus_wmask_o,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          rdata_valid_o,
  output logic          stall_o,
  output logic          mem_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          bus_req_q, bus_we_q, rdata_valid_q;
  logic [AW-1:0] bus_addr_q;
  logic [DW-1:0] bus_wdata_q, rdata_q;
  logic [3:0]    bus_wmask_q;
  logic [2:0]    lat_f3_q;
  logic [1:0]    lat_off_q;

  logic          f3_ok, align_ok, req_legal, req_present;
  logic [DW-1:0] st_data;
  logic [3:0]    st_mask;
  logic [DW-1:0] ld_shift, ld_fmt;

  assign req_present = memrq_i | memwq_i;

  // Stores only allow B/H/W; loads add the unsigned variants.
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    if (memwq_i) f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010};
    else         f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3_i[1:0])
      2'b01:   align_ok = ~addr_i[0];
      2'b10:   align_ok = (addr_i[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    req_legal = (memrq_i ^ memwq_i) & f3_ok & align_ok;
  end

  always_comb begin
    st_data = wdata_i;
    st_mask = 4'b0000;
    if (memwq_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          st_data = {4{wdata_i[7:0]}};
          st_mask = 4'b0001 << addr_i[1:0];
        end
        2'b01: begin
          st_data = {2{wdata_i[15:0]}};
          st_mask = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_data = wdata_i;
          st_mask = 4'b1111;
        end
      endcase
    end
  end

  // funct3[2] selects zero-extension for BU/HU.
  always_comb begin
    ld_shift = bus_rdata_i >> {lat_off_q, 3'b000};
    case (lat_f3_q[1:0])
      2'b00:   ld_fmt = {{24{ld_shift[7]  & ~lat_f3_q[2]}}, ld_shift[7:0]};
      2'b01:   ld_fmt = {{16{ld_shift[15] & ~lat_f3_q[2]}}, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_err_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_present) begin
          if (req_legal) begin
            stall_o = 1'b1;
            state_d = S_REQ;
          end else begin
            mem_err_o = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (bus_ack_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_wmask_q   <= 4'b0000;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      lat_f3_q      <= 3'b000;
      lat_off_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          rdata_valid_q <= 1'b0;
          if (req_present && req_legal) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= memwq_i;
            bus_addr_q  <= {addr_i[AW-1:2], 2'b00};
            bus_wdata_q <= st_data;
            bus_wmask_q <= st_mask;
            lat_f3_q    <= funct3_i;
            lat_off_q   <= addr_i[1:0];
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            bus_req_q     <= 1'b0;
            rdata_valid_q <= ~bus_we_q;
            if (!bus_we_q) rdata_q <= ld_fmt;
          end
        end
        default: rdata_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_wmask_o   = bus_wmask_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

endmodule
